// File: rtl/slice_cfg_pkg.sv
// Shared sizing helpers, frame field offsets and loader state encoding for
// the slicel configuration path.
package slice_cfg_pkg;

    function automatic int cfg_size(input int s_xx_base);
        return 2 * (2 ** s_xx_base) + 1;
    endfunction

    function automatic int mux_lvls(input int num_luts);
        return $clog2(num_luts);
    endfunction

    function automatic int frame_w(input int s_xx_base, input int num_luts);
        return cfg_size(s_xx_base) * num_luts + mux_lvls(num_luts) + 1 + 2 * num_luts;
    endfunction

    function automatic int num_words(input int s_xx_base, input int num_luts, input int word_w);
        return (frame_w(s_xx_base, num_luts) + word_w - 1) / word_w;
    endfunction

    // Field offsets inside the frame, LSB first.
    function automatic int mux_off(input int s_xx_base, input int num_luts);
        return cfg_size(s_xx_base) * num_luts;
    endfunction

    function automatic int cc_off(input int s_xx_base, input int num_luts);
        return mux_off(s_xx_base, num_luts) + mux_lvls(num_luts);
    endfunction

    function automatic int regs_off(input int s_xx_base, input int num_luts);
        return cc_off(s_xx_base, num_luts) + 1;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2,
        ST_ERR    = 2'd3
    } cfg_state_e;

endpackage

// File: rtl/slicel_cfg_loader.sv
// Streams a slice configuration frame in word by word, checks its length and
// pulses cen for one cycle so slicel latches the assembled configuration.
module slicel_cfg_loader
    import slice_cfg_pkg::*;
#(
    parameter int S_XX_BASE = 4,
    parameter int NUM_LUTS  = 4,
    parameter int WORD_W    = 8
) (
    input  logic                                         cclk,
    input  logic                                         rst_n,
    input  logic                                         cfg_valid,
    input  logic [WORD_W-1:0]                            cfg_data,
    input  logic                                         cfg_last,
    output logic                                         cfg_ready,
    input  logic                                         cfg_clear,
    output logic [cfg_size(S_XX_BASE)*NUM_LUTS-1:0]      luts_config_out,
    output logic [mux_lvls(NUM_LUTS)-1:0]                inter_lut_mux_config,
    output logic                                         config_use_cc,
    output logic [2*NUM_LUTS-1:0]                        regs_config_out,
    output logic                                         cen,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         err
);

    localparam int FRAME_W   = frame_w(S_XX_BASE, NUM_LUTS);
    localparam int NUM_WORDS = num_words(S_XX_BASE, NUM_LUTS, WORD_W);
    localparam int LUT_BITS  = cfg_size(S_XX_BASE) * NUM_LUTS;
    localparam int MUX_LVLS  = mux_lvls(NUM_LUTS);
    localparam int MUX_OFF   = mux_off(S_XX_BASE, NUM_LUTS);
    localparam int CC_OFF    = cc_off(S_XX_BASE, NUM_LUTS);
    localparam int REGS_OFF  = regs_off(S_XX_BASE, NUM_LUTS);
    localparam int CNT_W     = $clog2(NUM_WORDS + 1);

    cfg_state_e           state_reg, state_next;
    logic [CNT_W-1:0]     cnt_reg, cnt_next;
    logic [FRAME_W-1:0]   frame_reg, frame_next;
    logic [NUM_WORDS-1:0] wr_en;
    logic                 accept;

    assign cfg_ready = (state_reg == ST_IDLE) || (state_reg == ST_LOAD);
    assign accept    = cfg_valid && cfg_ready;

    // The counter is 0 in IDLE, so one index compare covers the first word too.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_WORDS; gi++) begin : g_word_en
            assign wr_en[gi] = accept && (cnt_reg == CNT_W'(gi));
        end
        for (gi = 0; gi < FRAME_W; gi++) begin : g_frame_bit
            assign frame_next[gi] = wr_en[gi / WORD_W] ? cfg_data[gi % WORD_W] : frame_reg[gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    cnt_next   = CNT_W'(1);
                    state_next = (NUM_WORDS == 1 && cfg_last) ? ST_COMMIT : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_W'(NUM_WORDS - 1))
                        state_next = cfg_last ? ST_COMMIT : ST_ERR;
                    else if (cfg_last)
                        state_next = ST_ERR;
                end
            end
            ST_COMMIT: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
            ST_ERR: begin
                if (cfg_clear) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            frame_reg <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            frame_reg <= frame_next;
        end
    end

    assign luts_config_out      = frame_reg[LUT_BITS-1:0];
    assign inter_lut_mux_config = frame_reg[MUX_OFF +: MUX_LVLS];
    assign config_use_cc        = frame_reg[CC_OFF];
    assign regs_config_out      = frame_reg[REGS_OFF +: 2*NUM_LUTS];

    assign cen  = (state_reg == ST_COMMIT);
    assign done = (state_reg == ST_COMMIT);
    assign busy = (state_reg == ST_LOAD);
    assign err  = (state_reg == ST_ERR);

endmodule

// File: tb/tb_slicel_cfg_loader.sv
// Bench for slicel_cfg_loader: directed scenarios plus random frames, all
// checked every cycle against a frame-level model of the loader.
module tb_slicel_cfg_loader;

    localparam int WORD_W    = 8;
    localparam int NUM_WORDS = 18;
    localparam int FRAME_W   = 143;
    localparam int LUT_BITS  = 132;
    localparam int MUX_OFF   = 132;
    localparam int CC_OFF    = 134;
    localparam int REGS_OFF  = 135;

    logic                cclk;
    logic                rst_n;
    logic                cfg_valid;
    logic [WORD_W-1:0]   cfg_data;
    logic                cfg_last;
    logic                cfg_ready;
    logic                cfg_clear;
    logic [LUT_BITS-1:0] luts_config_out;
    logic [1:0]          inter_lut_mux_config;
    logic                config_use_cc;
    logic [7:0]          regs_config_out;
    logic                cen;
    logic                busy;
    logic                done;
    logic                err;

    slicel_cfg_loader #(
        .S_XX_BASE (4),
        .NUM_LUTS  (4),
        .WORD_W    (WORD_W)
    ) dut (
        .cclk                 (cclk),
        .rst_n                (rst_n),
        .cfg_valid            (cfg_valid),
        .cfg_data             (cfg_data),
        .cfg_last             (cfg_last),
        .cfg_ready            (cfg_ready),
        .cfg_clear            (cfg_clear),
        .luts_config_out      (luts_config_out),
        .inter_lut_mux_config (inter_lut_mux_config),
        .config_use_cc        (config_use_cc),
        .regs_config_out      (regs_config_out),
        .cen                  (cen),
        .busy                 (busy),
        .done                 (done),
        .err                  (err)
    );

    initial cclk = 1'b0;
    always #5 cclk = ~cclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cen_count = 0;
    bit chk_en = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: words received so far, error flag, pending commit.
    logic [FRAME_W-1:0] m_frame;
    int  m_cnt;
    bit  m_err;
    bit  m_commit;

    always @(posedge cclk or negedge rst_n) begin
        if (!rst_n) begin
            m_frame  = '0;
            m_cnt    = 0;
            m_err    = 0;
            m_commit = 0;
        end else if (m_commit) begin
            m_commit = 0;
            m_cnt    = 0;
        end else if (m_err) begin
            if (cfg_clear) begin
                m_err = 0;
                m_cnt = 0;
            end
        end else if (cfg_valid) begin
            for (int b = 0; b < WORD_W; b++)
                if (m_cnt * WORD_W + b < FRAME_W)
                    m_frame[m_cnt * WORD_W + b] = cfg_data[b];
            m_cnt++;
            if (m_cnt == NUM_WORDS) begin
                if (cfg_last) m_commit = 1;
                else          m_err = 1;
            end else if (cfg_last && m_cnt > 1) begin
                m_err = 1;
            end
        end
    end

    always @(negedge cclk) begin
        if (cen) cen_count++;
        if (chk_en) begin
            check("ready", cfg_ready, !m_err && !m_commit);
            check("cen",   cen,  m_commit);
            check("done",  done, m_commit);
            check("busy",  busy, (m_cnt > 0) && !m_err && !m_commit);
            check("err",   err,  m_err);
            check("luts",  luts_config_out, m_frame[LUT_BITS-1:0]);
            check("mux",   inter_lut_mux_config, m_frame[MUX_OFF +: 2]);
            check("cc",    config_use_cc, m_frame[CC_OFF]);
            check("regs",  regs_config_out, m_frame[REGS_OFF +: 8]);
        end
    end

    logic [7:0] fw [NUM_WORDS];
    bit rand_clear = 0;

    task automatic send(input logic [7:0] d, input bit lst, input int gap_max, input int wait_max,
                        output bit ok);
        bit rdy;
        int gaps;
        gaps = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
        repeat (gaps) begin
            cfg_valid = 0;
            cfg_clear = rand_clear ? 1'($urandom_range(0, 1)) : 1'b0;
            @(posedge cclk); #1;
        end
        cfg_clear = 0;
        cfg_valid = 1;
        cfg_data  = d;
        cfg_last  = lst;
        ok = 0;
        for (int t = 0; t < wait_max; t++) begin
            rdy = cfg_ready;
            @(posedge cclk); #1;
            if (rdy) begin
                ok = 1;
                break;
            end
        end
        cfg_valid = 0;
        cfg_last  = 0;
    endtask

    // Sends words 0..n-1 of fw with cfg_last on word last_idx (-1 for none).
    task automatic send_frame(input int n, input int last_idx, input int gap_max);
        bit ok;
        for (int i = 0; i < n; i++) begin
            send(fw[i], (i == last_idx), gap_max, 8, ok);
            check("word_accepted", ok, 1'b1);
        end
    endtask

    task automatic idle(input int n);
        cfg_valid = 0;
        repeat (n) begin
            @(posedge cclk); #1;
        end
    endtask

    task automatic clear_err();
        cfg_clear = 1;
        @(posedge cclk); #1;
        cfg_clear = 0;
    endtask

    initial begin
        int c0;
        bit ok;
        cfg_valid = 0;
        cfg_data  = '0;
        cfg_last  = 0;
        cfg_clear = 0;
        rst_n     = 1;
        #1 rst_n  = 0;
        repeat (2) @(posedge cclk);
        #1;
        check("rst_ready", cfg_ready, 1'b1);
        check("rst_cen",   cen, 1'b0);
        check("rst_err",   err, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_luts",  luts_config_out, '0);
        rst_n  = 1;
        chk_en = 1;
        idle(2);

        // Normal back-to-back frame.
        for (int i = 0; i < NUM_WORDS; i++) fw[i] = 8'(i);
        c0 = cen_count;
        send_frame(NUM_WORDS, NUM_WORDS - 1, 0);
        check("t1_cen_after_last",  cen, 1'b1);
        check("t1_done_after_last", done, 1'b1);
        check("t1_lut_lo",  luts_config_out[7:0], 8'h00);
        check("t1_lut_w1",  luts_config_out[15:8], 8'h01);
        check("t1_mux",     inter_lut_mux_config, 2'b01);
        check("t1_cc",      config_use_cc, 1'b0);
        check("t1_regs",    regs_config_out, 8'h22);
        idle(3);
        check("t1_cen_pulses", cen_count - c0, 1);

        // Same frame with random gaps.
        c0 = cen_count;
        send_frame(NUM_WORDS, NUM_WORDS - 1, 3);
        check("t2_cen_after_last", cen, 1'b1);
        check("t2_lut_w1", luts_config_out[15:8], 8'h01);
        check("t2_regs",   regs_config_out, 8'h22);
        idle(3);
        check("t2_cen_pulses", cen_count - c0, 1);

        // Early last on word 5.
        c0 = cen_count;
        send_frame(6, 5, 0);
        check("t3_err",   err, 1'b1);
        check("t3_ready", cfg_ready, 1'b0);
        idle(4);
        check("t3_no_cen", cen_count - c0, 0);
        clear_err();
        check("t3_clear_ready", cfg_ready, 1'b1);
        check("t3_clear_err",   err, 1'b0);

        // Missing last.
        c0 = cen_count;
        send_frame(NUM_WORDS, -1, 0);
        check("t4_err", err, 1'b1);
        send(8'hA5, 1'b0, 0, 4, ok);
        check("t4_not_accepted", ok, 1'b0);
        check("t4_no_cen", cen_count - c0, 0);
        clear_err();

        // Reset mid-frame.
        for (int i = 0; i < NUM_WORDS; i++) fw[i] = 8'($urandom);
        send_frame(9, -1, 0);
        rst_n = 0;
        #1;
        check("t5_rst_luts",  luts_config_out, '0);
        check("t5_rst_regs",  regs_config_out, '0);
        check("t5_rst_busy",  busy, 1'b0);
        check("t5_rst_ready", cfg_ready, 1'b1);
        @(posedge cclk); #1;
        rst_n = 1;
        c0 = cen_count;
        send_frame(NUM_WORDS, NUM_WORDS - 1, 1);
        check("t5_cen", cen, 1'b1);
        idle(2);
        check("t5_cen_pulses", cen_count - c0, 1);

        // Padding word.
        for (int i = 0; i < NUM_WORDS; i++) fw[i] = 8'(i);
        fw[NUM_WORDS - 1] = 8'hFF;
        send_frame(NUM_WORDS, NUM_WORDS - 1, 0);
        check("t6_regs", regs_config_out, 8'hFE);
        check("t6_cc",   config_use_cc, 1'b0);
        check("t6_mux",  inter_lut_mux_config, 2'b01);
        idle(2);

        // Random frames, some with length errors and stray clears.
        rand_clear = 1;
        for (int f = 0; f < 30; f++) begin
            int kind;
            int last_idx;
            for (int i = 0; i < NUM_WORDS; i++) fw[i] = 8'($urandom);
            kind = $urandom_range(0, 9);
            if (kind == 0)      last_idx = -1;
            else if (kind == 1) last_idx = $urandom_range(1, NUM_WORDS - 2);
            else                last_idx = NUM_WORDS - 1;
            send_frame((last_idx < 0) ? NUM_WORDS : last_idx + 1, last_idx, 2);
            idle($urandom_range(0, 2));
            if (err) clear_err();
        end
        rand_clear = 0;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
